// File: rtl/pipe_pkg.sv
// pipe_pkg: shared exception codes, PC defaults and per-boundary payload widths
package pipe_pkg;
   localparam int EXC_W = 5;
   localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
   localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
   localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
   localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
   localparam int DATA_W_FD = 32;
   localparam int DATA_W_DE = 96;
   localparam int DATA_W_EM = 96;
   localparam int DATA_W_MW = 64;
   localparam int DEF_DATA_W = 96;
   localparam int DEF_CNT_W = 16;
   function automatic logic has_exc(input logic [EXC_W-1:0] code);
      return code != EXC_NONE;
   endfunction
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, synchronous clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk)
      if (clr) cnt <= '0;
      else if (en && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage register with bubble/flush sideband and stall counter
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PC_W = 32,
   parameter int EXC_W = 5,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
   parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(DEF_HANDLER_PC),
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              bubble,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              in_bd,
   input  logic [EXC_W-1:0]  in_exccode,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_bd,
   output logic [EXC_W-1:0]  out_exccode,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);
   always_ff @(posedge clk)
      if (reset) begin
         out_valid   <= 1'b0;
         out_pc      <= RESET_PC;
         out_bd      <= 1'b0;
         out_exccode <= '0;
         out_data    <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         out_pc      <= HANDLER_PC;
         out_bd      <= 1'b0;
         out_exccode <= '0;
         out_data    <= '0;
      end else if (!stall) begin
         // a bubble keeps PC/BD so EPC stays correct for the slot it replaces
         out_valid   <= bubble ? 1'b0 : in_valid;
         out_pc      <= in_pc;
         out_bd      <= in_bd;
         out_exccode <= bubble ? '0 : in_exccode;
         out_data    <= bubble ? '0 : in_data;
      end
   sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .clr (reset),
      .en  (stall && out_valid && !flush),
      .cnt (stall_cnt)
   );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios plus random traffic against a priority-rule model
module tb_pipe_stage_reg;
   localparam int DW = 96;
   logic clk = 0, reset, stall, bubble, flush, in_valid, in_bd;
   logic [31:0] in_pc;
   logic [4:0] in_exccode;
   logic [DW-1:0] in_data;
   logic out_valid, out_bd;
   logic [31:0] out_pc;
   logic [4:0] out_exccode;
   logic [DW-1:0] out_data;
   logic [3:0] stall_cnt;
   int errors = 0, checks = 0;
   logic m_valid, m_bd;
   logic [31:0] m_pc;
   logic [4:0] m_exc;
   logic [DW-1:0] m_data;
   int m_cnt;

   pipe_stage_reg #(.CNT_W(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exccode(in_exccode),
      .in_data(in_data), .out_valid(out_valid), .out_pc(out_pc), .out_bd(out_bd),
      .out_exccode(out_exccode), .out_data(out_data), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      logic nv, nb;
      logic [31:0] np;
      logic [4:0] ne;
      logic [DW-1:0] nd;
      int nc;
      {nv, np, nb, ne, nd} = {m_valid, m_pc, m_bd, m_exc, m_data};
      nc = m_cnt;
      if (reset) begin
         {nv, np, nb, ne, nd} = {1'b0, 32'h3000, 1'b0, 5'd0, {DW{1'b0}}};
         nc = 0;
      end else begin
         if (stall && m_valid && !flush && m_cnt < 15) nc = m_cnt + 1;
         if (flush) {nv, np, nb, ne, nd} = {1'b0, 32'h4180, 1'b0, 5'd0, {DW{1'b0}}};
         else if (stall) ;
         else if (bubble) {nv, np, nb, ne, nd} = {1'b0, in_pc, in_bd, 5'd0, {DW{1'b0}}};
         else {nv, np, nb, ne, nd} = {in_valid, in_pc, in_bd, in_exccode, in_data};
      end
      @(posedge clk);
      {m_valid, m_pc, m_bd, m_exc, m_data} = {nv, np, nb, ne, nd};
      m_cnt = nc;
      #1;
   endtask

   task automatic drive(input logic r, s, b, f, v, input logic [31:0] pc, input logic bd,
                        input logic [4:0] e, input logic [DW-1:0] d);
      {reset, stall, bubble, flush, in_valid, in_pc, in_bd, in_exccode, in_data} = {r, s, b, f, v, pc, bd, e, d};
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 1, 32'h3010, 1, 5'd4, 96'h1234);
      tick(); tick();
      checks++; if (out_pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp %h", out_pc, 32'h3000); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
      checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_load_stall();
      drive(0, 0, 0, 0, 1, 32'h3020, 0, 5'd0, 96'hABCD);
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3020) begin errors++; $display("FAIL load got v=%b pc=%h exp v=1 pc=3020", out_valid, out_pc); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, i == 1, 0, 0, 32'h5000 + i, 1, 5'd12, 96'h5555 + i);
         tick();
      end
      checks++; if (out_pc !== 32'h3020 || out_data !== 96'hABCD) begin errors++; $display("FAIL stall_hold got pc=%h data=%h exp 3020/abcd", out_pc, out_data); end
      checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
   endtask

   task automatic test_bubble();
      drive(0, 0, 1, 0, 1, 32'h3044, 1, 5'd4, 96'hFEED);
      tick();
      checks++; if ({out_valid, out_pc, out_bd, out_exccode} !== {1'b0, 32'h3044, 1'b1, 5'd0}) begin
         errors++; $display("FAIL bubble got v=%b pc=%h bd=%b exc=%0d exp v=0 pc=3044 bd=1 exc=0", out_valid, out_pc, out_bd, out_exccode); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL bubble_data got %h exp 0", out_data); end
   endtask

   task automatic test_flush_priority();
      drive(0, 0, 0, 0, 1, 32'h3048, 1, 5'd10, 96'h77);
      tick();
      drive(1'b0, 1, 1, 1, 1, 32'h3100, 1, 5'd5, 96'h99);
      tick();
      checks++; if ({out_valid, out_pc, out_bd} !== {1'b0, 32'h4180, 1'b0}) begin
         errors++; $display("FAIL flush got v=%b pc=%h bd=%b exp v=0 pc=4180 bd=0", out_valid, out_pc, out_bd); end
      checks++; if (out_exccode !== 5'd0 || out_data !== '0) begin errors++; $display("FAIL flush_clear got exc=%0d data=%h exp 0/0", out_exccode, out_data); end
      checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL flush_cnt got %0d exp 3", stall_cnt); end
   endtask

   task automatic test_stall_invalid();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 0, 1, 32'h3200, 0, 5'd0, 96'h1);
         tick();
      end
      checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_invalid_cnt got %0d exp 3", stall_cnt); end
      checks++; if (out_pc !== 32'h4180) begin errors++; $display("FAIL stall_invalid_pc got %h exp 4180", out_pc); end
   endtask

   task automatic test_saturation();
      drive(0, 0, 0, 0, 1, 32'h3300, 0, 5'd0, 96'h2);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 0, 0, 0, 32'h0, 0, 5'd0, 96'h0);
         tick();
      end
      checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL saturate got %0d exp 15", stall_cnt); end
   endtask

   task automatic test_reset_mid_stall();
      drive(0, 0, 0, 0, 1, 32'h3020, 0, 5'd0, 96'h3);
      tick();
      drive(1, 1, 0, 0, 1, 32'h3024, 0, 5'd0, 96'h4);
      tick();
      checks++; if (out_pc !== 32'h3000) begin errors++; $display("FAIL reset_stall_pc got %h exp 3000", out_pc); end
      checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(99) < 3, $urandom_range(99) < 35, $urandom_range(99) < 20,
               $urandom_range(99) < 6, $urandom_range(99) < 80, $urandom, 1'($urandom),
               5'($urandom), {$urandom, $urandom, $urandom});
         tick();
         checks++;
         if ({out_valid, out_pc, out_bd, out_exccode, out_data} !== {m_valid, m_pc, m_bd, m_exc, m_data}) begin
            errors++; $display("FAIL rand_regs[%0d] got v=%b pc=%h bd=%b exc=%0d data=%h exp v=%b pc=%h bd=%b exc=%0d data=%h",
               i, out_valid, out_pc, out_bd, out_exccode, out_data, m_valid, m_pc, m_bd, m_exc, m_data); end
         checks++;
         if (stall_cnt !== 4'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", i, stall_cnt, m_cnt); end
      end
   endtask

   initial begin
      {m_valid, m_pc, m_bd, m_exc, m_data} = '0;
      m_cnt = 0;
      drive(1, 0, 0, 0, 0, 32'h0, 0, 5'd0, 96'h0);
      @(negedge clk);
      test_reset();
      test_load_stall();
      test_bubble();
      test_flush_priority();
      test_stall_invalid();
      test_saturation();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
